// File: rtl/output_drain_pkg.sv
// rtl/output_drain_pkg.sv - shared types and helpers for the output drain buffer
package output_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } drain_state_t;

    // Coordinate tag carried alongside every result.
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } result_tag_t;

    localparam int TAG_W = $bits(result_tag_t);

    // Full entry at the default 32-bit accumulator width; the top level
    // builds the same layout as {data, tag} for any accumulator width.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } result_entry_t;

    // Number of results one run produces, truncated to 32 bits.
    function automatic logic [31:0] calc_total(input int unsigned w,
                                               input int unsigned h,
                                               input int unsigned oc);
        longint unsigned prod;
        prod = longint'(w) * longint'(h) * longint'(oc);
        return prod[31:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [LOG2_DEPTH:0]   occupancy
);

    localparam logic [LOG2_DEPTH:0] DEPTH_L = (LOG2_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH-1:0] wr_ptr;

    // Pointer/occupancy bookkeeping; the caller only pops when non-empty and
    // only pushes when there is room (or a pop frees a slot this cycle).
    always_ff @(posedge clk) begin
        if (rst_in || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage array; left unreset because the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (push && !(rst_in || flush)) mem[wr_ptr] <= wdata;
    end

    assign empty = (occupancy == '0);
    assign full  = (occupancy == DEPTH_L);
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/output_drain_buffer.sv
// rtl/output_drain_buffer.sv - result capture FIFO with run FSM, counter and flags
module output_drain_buffer
    import output_drain_pkg::*;
#(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int LOG2_FIFO_DEPTH    = 3,
    parameter int ALMOST_FULL_SLACK  = 2,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic [31:0]                   in_x,
    input  logic [31:0]                   in_y,
    input  logic [31:0]                   in_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACCUMULATION_WIDTH-1:0] out_data,
    output logic [31:0]                   out_x,
    output logic [31:0]                   out_y,
    output logic [31:0]                   out_ch,
    output logic                          almost_full,
    output logic                          overflow,
    output logic [31:0]                   count,
    output logic                          done
);

    localparam logic [31:0] TOTAL =
        calc_total(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
    localparam int ENTRY_W = ACCUMULATION_WIDTH + TAG_W;
    localparam logic [LOG2_FIFO_DEPTH:0] AF_LEVEL =
        (LOG2_FIFO_DEPTH + 1)'(FIFO_DEPTH - ALMOST_FULL_SLACK);

    drain_state_t             state;
    drain_state_t             state_next;
    logic                     enter_collect;
    logic                     push_acc;
    logic                     pop_acc;
    logic                     lost;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [LOG2_FIFO_DEPTH:0] occ;
    logic [LOG2_FIFO_DEPTH:0] occ_next;
    result_tag_t              in_tag;
    result_tag_t              out_tag;
    logic [ENTRY_W-1:0]       wr_entry;
    logic [ENTRY_W-1:0]       rd_entry;

    assign in_tag              = '{x: in_x, y: in_y, ch: in_ch};
    assign wr_entry            = {in_data, in_tag};
    assign {out_data, out_tag} = rd_entry;
    assign out_x               = out_tag.x;
    assign out_y               = out_tag.y;
    assign out_ch              = out_tag.ch;
    assign out_valid           = !fifo_empty;
    assign pop_acc             = out_valid && out_ready;
    assign done                = (state == DONE);

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH      (FIFO_DEPTH),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_in    (rst_in),
        .flush     (enter_collect),
        .push      (push_acc),
        .pop       (pop_acc),
        .wdata     (wr_entry),
        .rdata     (rd_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occ)
    );

    // Next-state, push acceptance and lost-result detection.
    always_comb begin
        state_next    = state;
        enter_collect = 1'b0;
        push_acc      = 1'b0;
        lost          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = COLLECT;
                    enter_collect = 1'b1;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (!fifo_full || pop_acc) push_acc = 1'b1;
                    else                       lost     = 1'b1;
                end
                if (count == TOTAL) state_next = DRAIN;
            end
            DRAIN: begin
                lost = in_valid;
                if (fifo_empty) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next    = COLLECT;
                    enter_collect = 1'b1;
                end else begin
                    lost = in_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Occupancy after this edge, so almost_full can be registered without lag.
    always_comb begin
        occ_next = occ;
        if (push_acc && !pop_acc)      occ_next = occ + 1'b1;
        else if (!push_acc && pop_acc) occ_next = occ - 1'b1;
        if (enter_collect)             occ_next = '0;
    end

    // State, result counter and status flags.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state       <= IDLE;
            count       <= '0;
            overflow    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            state       <= state_next;
            almost_full <= (occ_next >= AF_LEVEL);
            if (enter_collect) begin
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_acc) count    <= count + 32'd1;
                if (lost)     overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_drain_buffer.sv
// tb/tb_output_drain_buffer.sv - self-checking bench for output_drain_buffer
module tb_output_drain_buffer;

    localparam int ACC_W = 32;
    localparam int DEPTH = 4;
    localparam int SLACK = 1;
    localparam int TOTAL = 2 * 2 * 2;

    typedef struct {
        logic [31:0] d;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_in, start, in_valid, out_ready;
    logic [ACC_W-1:0] in_data;
    logic [31:0]      in_x, in_y, in_ch;
    logic             out_valid, almost_full, overflow, done;
    logic [ACC_W-1:0] out_data;
    logic [31:0]      out_x, out_y, out_ch, count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of buffered results plus run bookkeeping.
    ent_t        q[$];
    logic [31:0] rx[$];
    int          m_phase = 0;
    int unsigned m_cnt   = 0;
    bit          m_ovf   = 1'b0;
    ent_t        ze      = '{d: 32'd0, x: 32'd0, y: 32'd0, ch: 32'd0};

    output_drain_buffer #(
        .ACCUMULATION_WIDTH (ACC_W),
        .FIFO_DEPTH         (DEPTH),
        .LOG2_FIFO_DEPTH    (2),
        .ALMOST_FULL_SLACK  (SLACK),
        .FEATURE_MAP_WIDTH  (2),
        .FEATURE_MAP_HEIGHT (2),
        .OUTPUT_NB_CHANNELS (2)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_ch       (in_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_ch      (out_ch),
        .almost_full (almost_full),
        .overflow    (overflow),
        .count       (count),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input int k);
        ent_t e;
        e.d  = 32'(k) * 32'h11;
        e.x  = 32'(k % 2);
        e.y  = 32'((k / 2) % 2);
        e.ch = 32'(k / 4);
        return e;
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit rst, input bit st, input bit iv, input ent_t e, input bit rdy);
        bit pop, acc, was_empty, enter;
        int unsigned pre_cnt;
        rst_in = rst; start = st; in_valid = iv; out_ready = rdy;
        in_data = e.d; in_x = e.x; in_y = e.y; in_ch = e.ch;
        if (!rst && out_valid && rdy) rx.push_back(out_data);
        if (rst) begin
            q.delete(); m_cnt = 0; m_ovf = 1'b0; m_phase = 0;
        end else begin
            pop       = (q.size() > 0) && rdy;
            was_empty = (q.size() == 0);
            pre_cnt   = m_cnt;
            enter     = (m_phase == 0 || m_phase == 3) && st;
            if (enter) begin
                q.delete(); m_cnt = 0; m_ovf = 1'b0; m_phase = 1;
            end else begin
                acc = (m_phase == 1) && iv && (q.size() < DEPTH || pop);
                if (m_phase == 1 && iv && !acc) m_ovf = 1'b1;
                if ((m_phase == 2 || m_phase == 3) && iv) m_ovf = 1'b1;
                if (pop) void'(q.pop_front());
                if (acc) begin q.push_back(e); m_cnt++; end
                if (m_phase == 1 && pre_cnt == TOTAL) m_phase = 2;
                else if (m_phase == 2 && was_empty) m_phase = 3;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_x", out_x, q[0].x);
            chk("out_y", out_y, q[0].y);
            chk("out_ch", out_ch, q[0].ch);
        end
        chk("almost_full", almost_full, q.size() >= DEPTH - SLACK);
        chk("count", count, m_cnt);
        chk("overflow", overflow, m_ovf);
        chk("done", done, m_phase == 3);
    endtask

    initial begin
        ent_t e;
        int   pushed;
        rst_in = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_x = '0; in_y = '0; in_ch = '0;

        // Reset state
        step(1, 0, 0, ze, 0);
        step(1, 0, 0, ze, 0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_out_ch", out_ch, 32'd0);

        // 1: full run with consumer always ready
        step(0, 1, 0, ze, 1);
        for (int k = 1; k <= 8; k++) step(0, 0, 1, mk(k), 1);
        chk("t1_count", count, 32'd8);
        for (int i = 0; i < 20 && !done; i++) step(0, 0, 0, ze, 1);
        chk("t1_done", done, 1'b1);
        chk("t1_ovf", overflow, 1'b0);

        // 2: consumer stalled, fifo fills, fifth result lost
        step(0, 1, 0, ze, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 1, mk(k), 0);
            if (k == 3) chk("t2_af_after_3", almost_full, 1'b1);
        end
        chk("t2_count", count, 32'd4);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_head", out_data, 32'h11);

        // 3: push and pop together while full
        step(1, 0, 0, ze, 0);
        step(0, 1, 0, ze, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 1, mk(k), 0);
        step(0, 0, 1, mk(9), 1);
        chk("t3_head", out_data, 32'h22);
        chk("t3_count", count, 32'd5);
        chk("t3_ovf", overflow, 1'b0);
        chk("t3_af", almost_full, 1'b1);

        // 4: reset mid-run, then in_valid without start is ignored
        step(1, 0, 0, ze, 0);
        step(0, 1, 0, ze, 0);
        for (int k = 1; k <= 3; k++) step(0, 0, 1, mk(k), 0);
        step(1, 0, 0, ze, 0);
        chk("t4_valid", out_valid, 1'b0);
        chk("t4_count", count, 32'd0);
        step(0, 0, 1, mk(4), 1);
        step(0, 0, 1, mk(5), 0);
        chk("t4_ignored_count", count, 32'd0);
        chk("t4_ignored_ovf", overflow, 1'b0);

        // 5: in_valid after done, then restart
        step(0, 1, 0, ze, 1);
        for (int k = 1; k <= 8; k++) step(0, 0, 1, mk(k), 1);
        for (int i = 0; i < 20 && !done; i++) step(0, 0, 0, ze, 1);
        chk("t5_done", done, 1'b1);
        step(0, 0, 1, mk(1), 1);
        chk("t5_ovf", overflow, 1'b1);
        chk("t5_valid", out_valid, 1'b0);
        step(0, 1, 0, ze, 1);
        chk("t5_restart_ovf", overflow, 1'b0);
        step(0, 0, 1, mk(3), 0);
        chk("t5_collect_count", count, 32'd1);

        // 6: random gaps and random backpressure
        step(1, 0, 0, ze, 0);
        step(0, 1, 0, ze, 0);
        rx.delete();
        pushed = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            bit iv;
            iv = (pushed < 8) && ($urandom_range(0, 2) != 0) && (q.size() < DEPTH);
            e = mk(pushed + 1);
            e.x = $urandom; e.y = $urandom; e.ch = $urandom;
            step(0, 0, iv, e, 1'($urandom_range(0, 1)));
            if (iv) pushed++;
        end
        chk("t6_done", done, 1'b1);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_rx_len", rx.size(), 8);
        for (int i = 0; i < 8 && i < rx.size(); i++)
            chk("t6_rx_order", rx[i], 32'(i + 1) * 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
